// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, memory freeze and operand forwarding.
// Control outputs are combinational from the registered state and current inputs; event counters are registered.
module hazard_ctrl (
  input  logic        clk,
  input  logic        PC_reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        ex_MemRead,
  input  logic [4:0]  ex_rs,
  input  logic [4:0]  ex_rt,
  input  logic        mem_RegWrite,
  input  logic [4:0]  mem_rd,
  input  logic        wb_RegWrite,
  input  logic [4:0]  wb_rd,
  input  logic        PCSrc,
  input  logic        mem_busy,
  output logic        PC_write,
  output logic        IF_ID_write,
  output logic        stage_en,
  output logic        ID_EX_bubble,
  output logic        IF_ID_flush,
  output logic        ID_EX_flush,
  output logic        EX_MEM_flush,
  output logic [1:0]  forward_A,
  output logic [1:0]  forward_B,
  output logic [1:0]  state,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);

  localparam logic [1:0] ST_RUN    = 2'b00;
  localparam logic [1:0] ST_STALL  = 2'b01;
  localparam logic [1:0] ST_FLUSH  = 2'b10;
  localparam logic [1:0] ST_FREEZE = 2'b11;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic        w_load_use;
  logic        w_stall_inc;
  logic        w_flush_inc;
  logic [15:0] r_stall_count;
  logic [15:0] r_flush_count;

  // Register 0 is hardwired to zero, so a match on it never creates a dependency.
  function automatic logic [1:0] fwd_sel(
    input logic       src_is_zero,
    input logic [4:0] src,
    input logic       m_we,
    input logic [4:0] m_rd,
    input logic       w_we,
    input logic [4:0] w_rd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (!src_is_zero && w_we && (w_rd == src)) begin
      sel = 2'b01;
    end
    if (!src_is_zero && m_we && (m_rd == src)) begin
      sel = 2'b10;
    end
    return sel;
  endfunction

  assign w_load_use = ex_MemRead && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  always_comb begin
    w_next_state = ST_RUN;
    PC_write     = 1'b1;
    IF_ID_write  = 1'b1;
    stage_en     = 1'b1;
    ID_EX_bubble = 1'b0;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    EX_MEM_flush = 1'b0;
    w_stall_inc  = 1'b0;
    w_flush_inc  = 1'b0;

    if (PC_reset) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      stage_en     = 1'b0;
      IF_ID_flush  = 1'b1;
      ID_EX_flush  = 1'b1;
      EX_MEM_flush = 1'b1;
    end else if (mem_busy) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      stage_en     = 1'b0;
      w_next_state = ST_FREEZE;
    end else if (r_state == ST_FLUSH) begin
      // The cycle after a redirect carries no valid hazards: wrong-path work was just squashed.
      w_next_state = ST_RUN;
    end else if (PCSrc) begin
      IF_ID_flush  = 1'b1;
      ID_EX_flush  = 1'b1;
      EX_MEM_flush = 1'b1;
      w_flush_inc  = 1'b1;
      w_next_state = ST_FLUSH;
    end else if ((r_state != ST_STALL) && w_load_use) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_bubble = 1'b1;
      w_stall_inc  = 1'b1;
      w_next_state = ST_STALL;
    end
  end

  always_comb begin
    forward_A = 2'b00;
    forward_B = 2'b00;
    if (!PC_reset) begin
      forward_A = fwd_sel(ex_rs == 5'd0, ex_rs, mem_RegWrite, mem_rd, wb_RegWrite, wb_rd);
      forward_B = fwd_sel(ex_rt == 5'd0, ex_rt, mem_RegWrite, mem_rd, wb_RegWrite, wb_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (PC_reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (PC_reset) begin
      r_stall_count <= 16'd0;
      r_flush_count <= 16'd0;
    end else begin
      if (w_stall_inc && (r_stall_count != CNT_MAX)) begin
        r_stall_count <= r_stall_count + 16'd1;
      end
      if (w_flush_inc && (r_flush_count != CNT_MAX)) begin
        r_flush_count <= r_flush_count + 16'd1;
      end
    end
  end

  assign state       = r_state;
  assign stall_count = r_stall_count;
  assign flush_count = r_flush_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expected vectors are queued as each step is driven and checked once outputs settle.
module tb_hazard_ctrl;

  localparam logic [1:0] RUN    = 2'b00;
  localparam logic [1:0] STALL  = 2'b01;
  localparam logic [1:0] FLUSH  = 2'b10;
  localparam logic [1:0] FREEZE = 2'b11;

  // {PC_write, IF_ID_write, stage_en, ID_EX_bubble, IF_ID_flush, ID_EX_flush, EX_MEM_flush}
  localparam logic [6:0] C_DEF = 7'b1110000;
  localparam logic [6:0] C_RST = 7'b0000111;
  localparam logic [6:0] C_FRZ = 7'b0000000;
  localparam logic [6:0] C_STL = 7'b0011000;
  localparam logic [6:0] C_FLS = 7'b1110111;

  typedef struct packed {
    logic [1:0]  st;
    logic [6:0]  ctl;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  logic        clk = 1'b0;
  logic        PC_reset;
  logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, mem_rd, wb_rd;
  logic        id_uses_rt, ex_MemRead, mem_RegWrite, wb_RegWrite, PCSrc, mem_busy;
  logic        PC_write, IF_ID_write, stage_en, ID_EX_bubble;
  logic        IF_ID_flush, ID_EX_flush, EX_MEM_flush;
  logic [1:0]  forward_A, forward_B, state;
  logic [15:0] stall_count, flush_count;

  exp_t        exp_q[$];
  logic [15:0] exp_sc;
  logic [15:0] exp_fc;
  int          n_chk  = 0;
  int          n_pass = 0;
  int          n_step = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk          (clk),
    .PC_reset     (PC_reset),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .ex_MemRead   (ex_MemRead),
    .ex_rs        (ex_rs),
    .ex_rt        (ex_rt),
    .mem_RegWrite (mem_RegWrite),
    .mem_rd       (mem_rd),
    .wb_RegWrite  (wb_RegWrite),
    .wb_rd        (wb_rd),
    .PCSrc        (PCSrc),
    .mem_busy     (mem_busy),
    .PC_write     (PC_write),
    .IF_ID_write  (IF_ID_write),
    .stage_en     (stage_en),
    .ID_EX_bubble (ID_EX_bubble),
    .IF_ID_flush  (IF_ID_flush),
    .ID_EX_flush  (ID_EX_flush),
    .EX_MEM_flush (EX_MEM_flush),
    .forward_A    (forward_A),
    .forward_B    (forward_B),
    .state        (state),
    .stall_count  (stall_count),
    .flush_count  (flush_count)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL step %0d %s: observed %h expected %h", n_step, tag, obs, expv);
  endtask

  // Expected values reflect the cycle being driven; counters show increments from earlier cycles.
  task automatic step(input logic [1:0] st, input logic [6:0] ctl,
                      input logic [1:0] fa, input logic [1:0] fb);
    exp_t e;
    e = {st, ctl, fa, fb, exp_sc, exp_fc};
    exp_q.push_back(e);
    #1;
    e = exp_q.pop_front();
    n_step++;
    check("state", {14'd0, state}, {14'd0, e.st});
    check("ctl", {9'd0, PC_write, IF_ID_write, stage_en, ID_EX_bubble,
                  IF_ID_flush, ID_EX_flush, EX_MEM_flush}, {9'd0, e.ctl});
    check("forward_A", {14'd0, forward_A}, {14'd0, e.fa});
    check("forward_B", {14'd0, forward_B}, {14'd0, e.fb});
    check("stall_count", stall_count, e.sc);
    check("flush_count", flush_count, e.fc);
    @(negedge clk);
  endtask

  task automatic clr();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; ex_MemRead = 1'b0;
    ex_rs = 5'd0; ex_rt = 5'd0; mem_RegWrite = 1'b0; mem_rd = 5'd0;
    wb_RegWrite = 1'b0; wb_rd = 5'd0; PCSrc = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic load_use5();
    ex_MemRead = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  initial begin
    clr();
    PC_reset = 1'b1;
    exp_sc = 16'd0;
    exp_fc = 16'd0;
    @(negedge clk);

    // Reset: forwarding forced to 00 even with a live match.
    mem_RegWrite = 1'b1; mem_rd = 5'd3; ex_rs = 5'd3;
    step(RUN, C_RST, 2'b00, 2'b00);
    PC_reset = 1'b0; clr();
    step(RUN, C_DEF, 2'b00, 2'b00);

    // Load-use on rs: one bubble, RUN->STALL->RUN; load-use masked during STALL.
    load_use5();
    step(RUN, C_STL, 2'b00, 2'b00);
    exp_sc = sat_inc(exp_sc);
    step(STALL, C_DEF, 2'b00, 2'b00);
    clr();
    step(RUN, C_DEF, 2'b00, 2'b00);

    // rt match only counts when the instruction reads rt.
    ex_MemRead = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b0;
    step(RUN, C_DEF, 2'b00, 2'b00);
    id_uses_rt = 1'b1;
    step(RUN, C_STL, 2'b00, 2'b00);
    exp_sc = sat_inc(exp_sc);
    clr();
    step(STALL, C_DEF, 2'b00, 2'b00);

    // Load into r0 is never a hazard.
    ex_MemRead = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    step(RUN, C_DEF, 2'b00, 2'b00);

    // Branch beats load-use; FLUSH masks both for one cycle.
    clr(); load_use5(); PCSrc = 1'b1;
    step(RUN, C_FLS, 2'b00, 2'b00);
    exp_fc = sat_inc(exp_fc);
    step(FLUSH, C_DEF, 2'b00, 2'b00);
    clr();
    step(RUN, C_DEF, 2'b00, 2'b00);

    // Forwarding priority and r0 exclusion.
    mem_RegWrite = 1'b1; wb_RegWrite = 1'b1; mem_rd = 5'd3; wb_rd = 5'd3;
    ex_rs = 5'd3; ex_rt = 5'd3;
    step(RUN, C_DEF, 2'b10, 2'b10);
    mem_RegWrite = 1'b0;
    step(RUN, C_DEF, 2'b01, 2'b01);
    mem_RegWrite = 1'b1; mem_rd = 5'd3; wb_rd = 5'd4; ex_rs = 5'd3; ex_rt = 5'd4;
    step(RUN, C_DEF, 2'b10, 2'b01);
    mem_rd = 5'd0; wb_rd = 5'd0; ex_rs = 5'd0; ex_rt = 5'd0;
    step(RUN, C_DEF, 2'b00, 2'b00);

    // Freeze holds a pending branch and keeps forwarding live; release fires the flush.
    clr(); mem_busy = 1'b1; PCSrc = 1'b1;
    mem_RegWrite = 1'b1; mem_rd = 5'd3; ex_rs = 5'd3;
    step(RUN, C_FRZ, 2'b10, 2'b00);
    step(FREEZE, C_FRZ, 2'b10, 2'b00);
    step(FREEZE, C_FRZ, 2'b10, 2'b00);
    mem_busy = 1'b0;
    step(FREEZE, C_FLS, 2'b10, 2'b00);
    exp_fc = sat_inc(exp_fc);
    clr();
    step(FLUSH, C_DEF, 2'b00, 2'b00);
    step(RUN, C_DEF, 2'b00, 2'b00);

    // Saturation: preload near the top, then keep stalling.
    force dut.r_stall_count = 16'hFFFD;
    #1;
    release dut.r_stall_count;
    exp_sc = 16'hFFFD;
    load_use5();
    for (int i = 0; i < 3; i++) begin
      step(RUN, C_STL, 2'b00, 2'b00);
      exp_sc = sat_inc(exp_sc);
      step(STALL, C_DEF, 2'b00, 2'b00);
    end
    clr();
    step(RUN, C_DEF, 2'b00, 2'b00);

    // Reset mid-STALL abandons the stall and clears counters.
    load_use5();
    step(RUN, C_STL, 2'b00, 2'b00);
    exp_sc = sat_inc(exp_sc);
    PC_reset = 1'b1;
    step(STALL, C_RST, 2'b00, 2'b00);
    PC_reset = 1'b0; clr();
    exp_sc = 16'd0;
    exp_fc = 16'd0;
    step(RUN, C_DEF, 2'b00, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk (rising edge) and PC_reset, sampled only on clk rising edge.
REQ-002 clk  in  1  pipeline clock.
REQ-003 PC_reset  in  1  synchronous active-high reset.
REQ-004 id_rs, id_rt  in  5 each  source register fields of the instruction in IF_ID.
REQ-005 id_uses_rt  in  1  ID instruction reads rt (R-type, sw, beq).
REQ-006 ex_MemRead  in  1  ID_EX holds a load.
REQ-007 ex_rs, ex_rt  in  5 each  source fields held in ID_EX; ex_rt is also the load destination.
REQ-008 mem_RegWrite, mem_rd  in  1, 5  EX_MEM write-back enable and destination.
REQ-009 wb_RegWrite, wb_rd  in  1, 5  MEM_WB write-back enable and destination.
REQ-010 PCSrc  in  1  branch taken, resolved in the MEM stage (from EX_MEM).
REQ-011 mem_busy  in  1  data memory not ready; freeze request.
REQ-012 PC_write, IF_ID_write  out  1 each  load enables for PC and IF_ID.
REQ-013 stage_en  out  1  load enable for ID_EX, EX_MEM, MEM_WB.
REQ-014 ID_EX_bubble  out  1  force all ID_EX control bits to zero.
REQ-015 IF_ID_flush, ID_EX_flush, EX_MEM_flush  out  1 each  clear register to NOP.
REQ-016 forward_A, forward_B  out  2 each  ALU operand select: 00 reg file, 10 EX_MEM result, 01 MEM_WB data.
REQ-017 state  out  2  RUN=00, STALL=01, FLUSH=10, FREEZE=11.
REQ-018 stall_count, flush_count  out  16 each  saturating event counters.

Function
REQ-019 State SHALL be registered; all enable/flush/forward outputs SHALL be combinational from state and current inputs.
REQ-020 load_use = ex_MemRead && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
REQ-021 Event priority each cycle: PC_reset > mem_busy > PCSrc > load_use.
REQ-022 Default (no event): PC_write=IF_ID_write=stage_en=1, ID_EX_bubble=0, all flushes=0.
REQ-023 mem_busy=1 in any non-reset state: PC_write=IF_ID_write=stage_en=0, no flush, no bubble, no counter change; next state FREEZE.
REQ-024 FREEZE: hold while mem_busy=1; on mem_busy=0 evaluate PCSrc/load_use exactly as in RUN in that same cycle (pending PCSrc held in EX_MEM is acted on then).
REQ-025 PCSrc=1 (RUN, STALL or FREEZE, mem_busy=0): IF_ID_flush=ID_EX_flush=EX_MEM_flush=1, PC_write=1 (loads target), flush_count+1; next state FLUSH; load_use ignored that cycle.
REQ-026 FLUSH lasts exactly one cycle: default outputs, load_use and PCSrc masked, then RUN (or FREEZE if mem_busy).
REQ-027 load_use in RUN: PC_write=IF_ID_write=0, stage_en=1, ID_EX_bubble=1, stall_count+1; next state STALL.
REQ-028 STALL lasts exactly one cycle: load_use masked, default outputs, next RUN; back-to-back loads thus cost one bubble each.
REQ-029 forward_A: 10 if mem_RegWrite && mem_rd!=0 && mem_rd==ex_rs; else 01 if wb_RegWrite && wb_rd!=0 && wb_rd==ex_rs; else 00. forward_B identical using ex_rt. EX_MEM match wins over MEM_WB.
REQ-030 Forwarding SHALL be computed in every non-reset state including FREEZE.
REQ-031 Counters saturate at 16'hFFFF; no wrap.

Reset
REQ-032 While PC_reset=1: state<=RUN, counters<=0; outputs PC_write=IF_ID_write=stage_en=0, all three flushes=1, ID_EX_bubble=0, forward_A=forward_B=00.
REQ-033 PC_reset asserted mid-STALL, FLUSH or FREEZE SHALL abandon the operation; first cycle after release is RUN with default outputs.

Verification
REQ-034 Load-use: ex_MemRead=1, ex_rt=5, id_rs=5 -> one cycle PC_write=0, IF_ID_write=0, ID_EX_bubble=1, state RUN->STALL->RUN, stall_count=1.
REQ-035 Branch: PCSrc=1 with load_use also true -> three flushes=1, PC_write=1, no bubble, flush_count=1, stall_count unchanged, state FLUSH one cycle.
REQ-036 Forward priority: mem_rd=wb_rd=ex_rs=3, both RegWrite=1 -> forward_A=10; mem_rd=0 with ex_rs=0 -> 00.
REQ-037 Freeze: mem_busy=1 for 3 cycles with PCSrc=1 -> all enables 0, state FREEZE, flush_count 0; release -> flush fires that cycle, flush_count=1.
REQ-038 Saturation/reset: force 65536 stalls -> stall_count=FFFF; PC_reset during STALL -> next cycle state=00, counters 0.
